eeg_pea_eng_feeder: RTL

Operand feeder for one EEG_PEA_ENG processing element. It reads activations from the activation RAM and weights from a local weight register file. From these it produces the PE input stream: DIN_VLD/DIN_RDY, ACT_DAT/ACT_ADD, WEI_DAT/WEI_IDX and ACT_LST/WEI_LST, in the address order and per-activation weight-index order the PE accumulator expects. It sits between the ARAM read port and the PE data input, one instance per PE.

---
 rtl/eeg_pea_eng_feeder_if.sv | 36 +++
 rtl/eeg_pea_eng_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/eeg_pea_eng_feeder_if.sv
// Operand stream bundle for one EEG_PEA_ENG processing element:
// the activation RAM read port plus the PE beat stream.
interface eeg_pea_eng_feeder_if #(
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3
);
    logic                   aram_rd_en;
    logic [ARAM_ADD_AW-1:0] aram_rd_add;
    logic [DATA_ACT_DW-1:0] aram_rd_dat;
    logic                   din_vld;
    logic                   din_rdy;
    logic [DATA_ACT_DW-1:0] act_dat;
    logic [ARAM_ADD_AW-1:0] act_add;
    logic [DATA_WEI_DW-1:0] wei_dat;
    logic [CONV_WEI_DW-1:0] wei_idx;
    logic                   act_lst;
    logic                   wei_lst;

    modport master (
        output aram_rd_en, aram_rd_add,
        input  aram_rd_dat,
        output din_vld,
        input  din_rdy,
        output act_dat, act_add, wei_dat, wei_idx, act_lst, wei_lst
    );

    modport slave (
        input  aram_rd_en, aram_rd_add,
        output aram_rd_dat,
        input  din_vld,
        output din_rdy,
        input  act_dat, act_add, wei_dat, wei_idx, act_lst, wei_lst
    );
endinterface

// File: rtl/eeg_pea_eng_feeder.sv
// Operand feeder for one PE: prefetches activations from ARAM into a 2-entry
// buffer and expands each into per-weight beats for the PE accumulator.
module eeg_pea_eng_feeder #(
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3,
    parameter int CONV_RUN_DW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   is_idle,
    output logic                   done,
    input  logic                   cfg_start,
    input  logic [ARAM_ADD_AW-1:0] cfg_act_base,
    input  logic [ARAM_ADD_AW-1:0] cfg_act_len,
    input  logic [CONV_RUN_DW-1:0] cfg_conv_run,
    input  logic [CONV_WEI_DW-1:0] cfg_conv_wei,
    input  logic                   cfg_skip_zero,
    input  logic                   wei_wr_en,
    input  logic [CONV_WEI_DW-1:0] wei_wr_idx,
    input  logic [DATA_WEI_DW-1:0] wei_wr_dat,
    eeg_pea_eng_feeder_if.master   bus
);
    localparam int WEI_DEPTH = 1 << CONV_WEI_DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [ARAM_ADD_AW-1:0] len_q;
    logic [CONV_RUN_DW-1:0] run_q;
    logic [CONV_WEI_DW-1:0] wei_q;
    logic                   skip_q;
    logic [DATA_WEI_DW-1:0] wreg [WEI_DEPTH];

    logic [ARAM_ADD_AW-1:0] rd_add_q, rd_cnt_q, pend_add_q, pop_cnt_q;
    logic                   pend_q, wp_q, rp_q;
    logic [1:0]             cnt_q;
    logic [DATA_ACT_DW-1:0] fifo_dat [2];
    logic [ARAM_ADD_AW-1:0] fifo_add [2];
    logic [CONV_WEI_DW-1:0] cur_k_q, sel_k;
    logic [WEI_DEPTH-1:0]   wmask;
    logic                   sel_found, wei_more;
    logic [DATA_ACT_DW-1:0] head_dat;
    logic [ARAM_ADD_AW-1:0] head_add;
    logic                   have_act, load, pop, rd_en, start, final_hs;
    logic [2:0]             occ;

    assign start    = (state_q == S_IDLE) && cfg_start;
    assign final_hs = bus.din_vld && bus.din_rdy && bus.act_lst && bus.wei_lst;
    assign is_idle  = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cfg_start) state_d = (cfg_act_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (final_hs)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            run_q  <= '0;
            wei_q  <= '0;
            skip_q <= 1'b0;
            for (int i = 0; i < WEI_DEPTH; i++) wreg[i] <= '0;
        end else if (state_q == S_IDLE) begin
            if (cfg_start) begin
                len_q  <= cfg_act_len;
                run_q  <= (cfg_conv_run == '0) ? CONV_RUN_DW'(1) : cfg_conv_run;
                wei_q  <= (cfg_conv_wei == '0) ? CONV_WEI_DW'(1) : cfg_conv_wei;
                skip_q <= cfg_skip_zero;
            end
            if (wei_wr_en) wreg[wei_wr_idx] <= wei_wr_dat;
        end
    end

    // Weight schedule: the emitted indices are the same for every activation.
    always_comb begin
        wmask     = '0;
        sel_k     = '0;
        sel_found = 1'b0;
        wei_more  = 1'b0;
        for (int i = 0; i < WEI_DEPTH; i++)
            if (i < int'(wei_q) && (!skip_q || wreg[i] != '0)) wmask[i] = 1'b1;
        if (wmask == '0) wmask[0] = 1'b1;
        for (int i = 0; i < WEI_DEPTH; i++) begin
            if (wmask[i] && i >= int'(cur_k_q)) begin
                if (!sel_found) begin
                    sel_k     = CONV_WEI_DW'(i);
                    sel_found = 1'b1;
                end else begin
                    wei_more  = 1'b1;
                end
            end
        end
    end

    // An empty buffer is bypassed so returning RAM data can be beaten out at once.
    assign head_dat = (cnt_q != '0) ? fifo_dat[rp_q] : bus.aram_rd_dat;
    assign head_add = (cnt_q != '0) ? fifo_add[rp_q] : pend_add_q;
    assign have_act = (cnt_q != '0) || pend_q;
    assign load     = (state_q == S_RUN) && have_act && (!bus.din_vld || bus.din_rdy);
    assign pop      = load && !wei_more;
    assign occ      = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
    assign rd_en    = (state_q == S_RUN) && (rd_cnt_q != len_q) && (occ < 3'd2);

    assign bus.aram_rd_en  = rd_en;
    assign bus.aram_rd_add = rd_add_q;

    // Stage p0: ARAM read issue, data return and prefetch buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_add_q   <= '0;
            rd_cnt_q   <= '0;
            pend_add_q <= '0;
            pop_cnt_q  <= '0;
            pend_q     <= 1'b0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= '0;
            cur_k_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_dat[i] <= '0;
                fifo_add[i] <= '0;
            end
        end else if (start) begin
            rd_add_q  <= cfg_act_base;
            rd_cnt_q  <= '0;
            pop_cnt_q <= '0;
            pend_q    <= 1'b0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= '0;
            cur_k_q   <= '0;
        end else begin
            pend_q <= rd_en;
            if (rd_en) begin
                rd_add_q   <= rd_add_q + ARAM_ADD_AW'(run_q);
                rd_cnt_q   <= rd_cnt_q + ARAM_ADD_AW'(1);
                pend_add_q <= rd_add_q;
            end
            if (pend_q) begin
                fifo_dat[wp_q] <= bus.aram_rd_dat;
                fifo_add[wp_q] <= pend_add_q;
                wp_q           <= ~wp_q;
            end
            if (pop) begin
                rp_q      <= ~rp_q;
                pop_cnt_q <= pop_cnt_q + ARAM_ADD_AW'(1);
            end
            cnt_q <= cnt_q + 2'(pend_q) - 2'(pop);
            if (load) cur_k_q <= pop ? '0 : sel_k + CONV_WEI_DW'(1);
        end
    end

    // Stage p1: registered beat towards the PE, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.din_vld <= 1'b0;
            bus.act_dat <= '0;
            bus.act_add <= '0;
            bus.wei_dat <= '0;
            bus.wei_idx <= '0;
            bus.act_lst <= 1'b0;
            bus.wei_lst <= 1'b0;
        end else if (load) begin
            bus.din_vld <= 1'b1;
            bus.act_dat <= head_dat;
            bus.act_add <= head_add;
            bus.wei_dat <= wreg[sel_k];
            bus.wei_idx <= sel_k;
            bus.act_lst <= (pop_cnt_q == len_q - ARAM_ADD_AW'(1));
            bus.wei_lst <= !wei_more;
        end else if (bus.din_rdy) begin
            bus.din_vld <= 1'b0;
            bus.act_lst <= 1'b0;
            bus.wei_lst <= 1'b0;
        end
    end
endmodule
